program_loader: RTL and testbench

- Receives a program image as a byte stream from the UART receiver and writes it, word by word, into instruction BRAM through the write port the core does not drive.
- Holds the core in reset (core_rstn low) until the image is fully written, then releases it.
- Packs bytes into the byte-swapped layout the core's fetch path expects: the first byte of each word lands in bits [31:24].

---
 rtl/program_loader.sv | 127 ++++++++++++
 tb/tb_program_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: turns a length-prefixed UART byte stream into 32-bit instruction
// BRAM writes and holds the core in reset until the whole image has landed.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] instr_addr,
  output logic [31:0] instr_din,
  output logic [3:0]  instr_we,
  output logic        core_rstn,
  output logic        load_done,
  output logic        load_error,
  output logic [31:0] words_loaded
);

  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;

  localparam logic [31:0] MAX_LIM = 32'(MAX_WORDS);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_len;
  logic [23:0] r_asm;
  logic [31:0] r_tcnt;
  logic        r_started;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [3:0]  r_we;
  logic        r_core_rstn;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_words;

  logic [31:0] w_hdr;
  logic [31:0] w_word;
  logic        w_timeout;

  // First byte received ends up in the most significant lane.
  assign w_hdr     = {r_len[23:0], rx_data};
  assign w_word    = {r_asm, rx_data};
  assign w_timeout = r_started && (r_tcnt == TO_LIM);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_LEN;
      r_idx       <= 2'd0;
      r_len       <= 32'd0;
      r_asm       <= 24'd0;
      r_tcnt      <= 32'd0;
      r_started   <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_din       <= 32'd0;
      r_we        <= 4'b0000;
      r_core_rstn <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_words     <= 32'd0;
    end else begin
      r_we <= 4'b0000;
      case (r_state)
        S_LEN, S_DATA: begin
          if (w_timeout) begin
            r_state     <= S_ERR;
            r_err       <= 1'b1;
            r_core_rstn <= 1'b0;
          end else if (rx_valid) begin
            r_tcnt    <= 32'd0;
            r_started <= 1'b1;
            r_idx     <= r_idx + 2'd1;
            if (r_state == S_LEN) begin
              r_len <= w_hdr;
              if (r_idx == 2'd3) begin
                if (w_hdr == 32'd0) begin
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_core_rstn <= 1'b1;
                end else if (w_hdr > MAX_LIM) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                end else begin
                  r_state <= S_DATA;
                end
              end
            end else begin
              r_asm <= w_word[23:0];
              // Word complete: the write pulse is registered on this same edge.
              if (r_idx == 2'd3) begin
                r_we    <= 4'b1111;
                r_din   <= w_word;
                r_addr  <= BASE_ADDR + {r_words[29:0], 2'b00};
                r_words <= r_words + 32'd1;
                if (r_words + 32'd1 == r_len)
                  r_state <= S_DONE;
              end
            end
          end else if (r_started) begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_core_rstn <= 1'b1;
        end
        S_ERR: begin
          r_err       <= 1'b1;
          r_core_rstn <= 1'b0;
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign instr_addr   = r_addr;
  assign instr_din    = r_din;
  assign instr_we     = r_we;
  assign core_rstn    = r_core_rstn;
  assign load_done    = r_done;
  assign load_error   = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances, one with small limits for
// length/timeout cases and one with a non-zero base address for reset-mid-load.
module tb_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn0, rstn1;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [31:0] a0, d0, wl0, a1, d1, wl1;
  logic [3:0]  we0, we1;
  logic        crst0, done0, err0, crst1, done1, err1;

  program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(4), .TIMEOUT_CYCLES(50)) u0 (
    .clk(clk), .rstn(rstn0), .rx_data(rx_data), .rx_valid(rx_valid),
    .instr_addr(a0), .instr_din(d0), .instr_we(we0), .core_rstn(crst0),
    .load_done(done0), .load_error(err0), .words_loaded(wl0));

  program_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(4096), .TIMEOUT_CYCLES(1000)) u1 (
    .clk(clk), .rstn(rstn1), .rx_data(rx_data), .rx_valid(rx_valid),
    .instr_addr(a1), .instr_din(d1), .instr_we(we1), .core_rstn(crst1),
    .load_done(done1), .load_error(err1), .words_loaded(wl1));

  int cyc = 0;
  int last_rx = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rx_valid) last_rx <= cyc + 1;

  // Write-pulse recorders, cleared while the matching instance is in reset.
  int          n_wr0 = 0;
  logic [31:0] wa[4];
  logic [31:0] wd[4];
  logic [3:0]  wwe[4];
  int          wc[4];
  int          done_cyc = -1;
  int          err_cyc = -1;
  always @(negedge clk) begin
    if (!rstn0) begin
      n_wr0 <= 0; done_cyc <= -1; err_cyc <= -1;
    end else begin
      if (we0 != 4'b0000) begin
        wa[n_wr0[1:0]]  <= a0;
        wd[n_wr0[1:0]]  <= d0;
        wwe[n_wr0[1:0]] <= we0;
        wc[n_wr0[1:0]]  <= cyc;
        n_wr0 <= n_wr0 + 1;
      end
      if (done0 && done_cyc < 0) done_cyc <= cyc;
      if (err0 && err_cyc < 0) err_cyc <= cyc;
    end
  end

  int          n_wr1 = 0;
  logic [31:0] la1 = 32'd0, ld1 = 32'd0;
  always @(negedge clk) begin
    if (!rstn1) n_wr1 <= 0;
    else if (we1 != 4'b0000) begin
      la1 <= a1; ld1 <= d1; n_wr1 <= n_wr1 + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Sends the n low-order bytes of v, most significant first, one every gap cycles.
  task automatic send(input logic [95:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = v[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      if (gap > 1) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic reset0();
    @(negedge clk); rstn0 = 1'b0;
    @(negedge clk); @(negedge clk); rstn0 = 1'b1;
  endtask

  task automatic check_two_words(input string t);
    chk({t, "_nwr"},   32'(n_wr0), 32'd2);
    chk({t, "_we0"},   32'(wwe[0]), 32'hF);
    chk({t, "_addr0"}, wa[0], 32'h0);
    chk({t, "_din0"},  wd[0], 32'h1305_1000);
    chk({t, "_addr1"}, wa[1], 32'h4);
    chk({t, "_din1"},  wd[1], 32'h6F00_0000);
    chk({t, "_words"}, wl0, 32'd2);
    chk({t, "_done"},  32'(done0), 32'd1);
    chk({t, "_crst"},  32'(crst0), 32'd1);
    chk({t, "_wr2lat"}, 32'(wc[1] - last_rx), 32'd0);
    chk({t, "_donelat"}, 32'(done_cyc - wc[1]), 32'd1);
    chk({t, "_we_idle"}, 32'(we0), 32'd0);
  endtask

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

    wait_cyc(3);
    chk("rst_addr", a0, 32'h0);
    chk("rst_din", d0, 32'h0);
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_crst", 32'(crst0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_words", wl0, 32'd0);

    // Two-word image, slow byte rate.
    @(negedge clk); rstn0 = 1'b1;
    send(96'h00000002_13051000_6F000000, 12, 10);
    wait_cyc(5);
    check_two_words("slow");

    // Same image back to back.
    reset0();
    send(96'h00000002_13051000_6F000000, 12, 1);
    wait_cyc(5);
    check_two_words("burst");

    // Empty image.
    reset0();
    send(96'h0, 4, 1);
    wait_cyc(4);
    chk("empty_nwr", 32'(n_wr0), 32'd0);
    chk("empty_done", 32'(done0), 32'd1);
    chk("empty_crst", 32'(crst0), 32'd1);
    chk("empty_lat", 32'(done_cyc - last_rx), 32'd0);

    // Oversized header.
    reset0();
    send(96'h00000005, 4, 1);
    wait_cyc(2);
    chk("len_err", 32'(err0), 32'd1);
    chk("len_crst", 32'(crst0), 32'd0);
    send(96'h11223344_55667788, 8, 1);
    wait_cyc(3);
    chk("len_nwr", 32'(n_wr0), 32'd0);
    chk("len_err_hold", 32'(err0), 32'd1);
    chk("len_done", 32'(done0), 32'd0);

    // Stream stalls partway through word 1.
    reset0();
    send(96'h00000002_13051000_6F, 9, 1);
    wait_cyc(60);
    chk("to_nwr", 32'(n_wr0), 32'd1);
    chk("to_addr", wa[0], 32'h0);
    chk("to_din", wd[0], 32'h1305_1000);
    chk("to_lat", 32'(err_cyc - last_rx), 32'd51);
    chk("to_err", 32'(err0), 32'd1);
    chk("to_words", wl0, 32'd1);
    chk("to_crst", 32'(crst0), 32'd0);
    chk("to_done", 32'(done0), 32'd0);

    // Reset in the middle of a load on the base-0x100 instance.
    @(negedge clk); rstn1 = 1'b1;
    send(96'h00000002_13051000_6F00, 10, 1);
    wait_cyc(2);
    chk("mid_nwr", 32'(n_wr1), 32'd1);
    chk("mid_words", wl1, 32'd1);
    @(negedge clk); rstn1 = 1'b0;
    wait_cyc(1);
    chk("mid_rst_addr", a1, 32'h100);
    chk("mid_rst_din", d1, 32'h0);
    chk("mid_rst_we", 32'(we1), 32'd0);
    chk("mid_rst_crst", 32'(crst1), 32'd0);
    chk("mid_rst_done", 32'(done1), 32'd0);
    chk("mid_rst_err", 32'(err1), 32'd0);
    chk("mid_rst_words", wl1, 32'd0);
    @(negedge clk); rstn1 = 1'b1;
    send(96'h00000001_DEADBEEF, 8, 1);
    wait_cyc(3);
    chk("reload_nwr", 32'(n_wr1), 32'd1);
    chk("reload_addr", la1, 32'h100);
    chk("reload_din", ld1, 32'hDEAD_BEEF);
    chk("reload_words", wl1, 32'd1);
    chk("reload_done", 32'(done1), 32'd1);
    chk("reload_crst", 32'(crst1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
